// File: rtl/writeback_stage_pkg.sv
// Shared types and constants for the MEM/WB writeback stage.
// Writeback source codes, halt FSM encoding and default widths.
package writeback_stage_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_CNT_W  = 32;

    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_LINK = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } wb_state_e;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM-to-WB bus: retiring instruction fields in, register file write and status out.
// The master is the MEM stage / decode side, the slave is the writeback stage.
interface writeback_stage_if
    import writeback_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic              mem_valid;
    logic              mem_flush;
    logic              mem_regWrite;
    logic [1:0]        mem_wbSel;
    logic              mem_halt;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_alu;
    logic [DATA_W-1:0] mem_load;
    logic [DATA_W-1:0] mem_pc4;
    logic [ADDR_W-1:0] rs_1;
    logic [ADDR_W-1:0] rt_2;

    logic [ADDR_W-1:0] rd_w;
    logic [DATA_W-1:0] writeData;
    logic              regWrite;
    logic              byp1_hit;
    logic              byp2_hit;
    logic [CNT_W-1:0]  retired;
    logic              halted;

    modport master (
        output mem_valid, mem_flush, mem_regWrite, mem_wbSel, mem_halt,
               mem_rd, mem_alu, mem_load, mem_pc4, rs_1, rt_2,
        input  rd_w, writeData, regWrite, byp1_hit, byp2_hit, retired, halted
    );

    modport slave (
        input  mem_valid, mem_flush, mem_regWrite, mem_wbSel, mem_halt,
               mem_rd, mem_alu, mem_load, mem_pc4, rs_1, rt_2,
        output rd_w, writeData, regWrite, byp1_hit, byp2_hit, retired, halted
    );

endinterface

// File: rtl/writeback_stage_wb_select.sv
// Writeback data mux: ALU result, load data or link address; the reserved code yields 0.
module wb_select
    import writeback_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [1:0]        sel_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] load_i,
    input  logic [DATA_W-1:0] pc4_i,
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        data_o = '0;
        case (wb_sel_e'(sel_i))
            WB_ALU:  data_o = alu_i;
            WB_LOAD: data_o = load_i;
            WB_LINK: data_o = pc4_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and register file write driver, with decode bypass,
// retire counter and a halt FSM that leaves HALTED only through reset.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    writeback_stage_if.slave   bus
);

    wb_state_e         state_q, state_d;
    logic              captureEn;
    logic              haltedOut;

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              regWrite_q, regWrite_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic [DATA_W-1:0] selData;
    logic              take;

    wb_select #(.DATA_W(DATA_W)) u_wb_select (
        .sel_i  (bus.mem_wbSel),
        .alu_i  (bus.mem_alu),
        .load_i (bus.mem_load),
        .pc4_i  (bus.mem_pc4),
        .data_o (selData)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A halt retires only if it is real and not flushed; flush wins over halt.
    always_comb begin
        state_d = state_q;
        if (state_q == RUN && bus.mem_valid && !bus.mem_flush && bus.mem_halt) begin
            state_d = HALTED;
        end
    end

    always_comb begin
        captureEn = (state_q == RUN);
        haltedOut = (state_q == HALTED);
    end

    // Bubbles, flushes and anything arriving while halted load an all-zero entry.
    always_comb begin
        take       = captureEn & bus.mem_valid & ~bus.mem_flush;
        valid_d    = take;
        rd_d       = '0;
        data_d     = '0;
        regWrite_d = 1'b0;
        retired_d  = retired_q + {{(CNT_W-1){1'b0}}, take};
        if (take) begin
            rd_d       = bus.mem_rd;
            data_d     = selData;
            regWrite_d = bus.mem_regWrite & ~bus.mem_halt &
                         (bus.mem_rd != ADDR_W'(REG_ZERO));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            rd_q       <= '0;
            data_q     <= '0;
            regWrite_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
            regWrite_q <= regWrite_d;
            retired_q  <= retired_d;
        end
    end

    assign bus.rd_w      = rd_q;
    assign bus.writeData = data_q;
    assign bus.regWrite  = regWrite_q & valid_q;
    assign bus.byp1_hit  = bus.regWrite & (bus.rs_1 == rd_q);
    assign bus.byp2_hit  = bus.regWrite & (bus.rt_2 == rd_q);
    assign bus.retired   = retired_q;
    assign bus.halted    = haltedOut;

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register plus writeback select for the MIPS pipeline.
- Sole driver of the decode register file write port (rd_w, writeData, regWrite).
- Captures one retiring instruction per cycle and chooses ALU result, load data or link address.
- Also provides a same-cycle decode bypass, a retire counter and a halt state machine.

Parameters:
- DATA_W, 32, datapath width
- ADDR_W, 5, register address width
- CNT_W, 32, retire counter width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous active-low reset
- mem_valid  in  1  MEM stage holds a real instruction (0 = bubble)
- mem_flush  in  1  kill the instruction being captured this edge
- mem_regWrite  in  1  instruction writes a register
- mem_wbSel  in  2  writeback source: 00 ALU, 01 load data, 10 PC+4 (link), 11 reserved
- mem_halt  in  1  instruction is syscall/halt
- mem_rd  in  ADDR_W  destination register
- mem_alu  in  DATA_W  ALU result
- mem_load  in  DATA_W  load data
- mem_pc4  in  DATA_W  PC+4
- rs_1  in  ADDR_W  decode read address 1, used for the bypass compare
- rt_2  in  ADDR_W  decode read address 2
- rd_w  out  ADDR_W  register file write address
- writeData  out  DATA_W  register file write data
- regWrite  out  1  register file write enable
- byp1_hit  out  1  rs_1 matches the pending write; use writeData
- byp2_hit  out  1  rt_2 matches the pending write
- retired  out  CNT_W  count of retired instructions
- halted  out  1  halt has retired

Behaviour:
- Reset: rst_n sampled at posedge; active low; synchronous. One clock domain.
- Reset values:
  - Stage register: valid=0, rd=0, data=0, regWrite=0.
  - Outputs: rd_w=0, writeData=0, regWrite=0, byp1_hit=0, byp2_hit=0, retired=0, halted=0.
  - FSM: RUN.
- Capture: each posedge in RUN, the stage loads mem_* and selects data by mem_wbSel. wbSel=11 selects 0.
- Latency: an instruction presented at edge N appears on rd_w/writeData/regWrite during cycle N..N+1. The register file commits it at edge N+1.
- Stage regWrite = mem_valid & ~mem_flush & mem_regWrite & (mem_rd != 0). Writes to $0 are always suppressed.
- Bubble (mem_valid=0) or flush: the stage loads valid=0 and regWrite=0. rd and data are don't-care but are held at 0.
- Outputs rd_w, writeData and regWrite come straight from the stage flops, with no combinational path from mem_*.
- Bypass (combinational): byp1_hit = regWrite & (rs_1 == rd_w); likewise byp2_hit for rt_2. Rd 0 never hits because regWrite is already 0 for it.
- retired: increments by 1 on an edge where the stage holds valid and is not flushed, counted at the capture edge. Wraps modulo 2^CNT_W.
- FSM:
  - RUN: normal operation.
  - RUN -> HALTED at an edge capturing mem_valid & ~mem_flush & mem_halt. The halt is itself counted in retired and its regWrite is forced 0.
  - HALTED: the stage captures only bubbles; all mem_* are ignored; regWrite stays 0; retired is frozen; halted=1.
  - HALTED -> RUN only via reset.
- Flush and halt together: the flush wins, so there is no halt and no count.
- Reset mid-operation: the pending write is dropped (regWrite=0 on the next cycle) and halted clears.

Decomposition:
- Shared package holds:
  - WB_ALU/WB_LOAD/WB_LINK/WB_RSVD codes.
  - RUN/HALTED state encoding.
  - REG_ZERO constant.
  - Default DATA_W/ADDR_W values.
- One natural sub-module, wb_select: the 4:1 writeback data mux, purely combinational. Everything else stays flat.

Test Plan:
- ALU write: wbSel=00, rd=5, alu=0x0000_1234, valid=1 -> next cycle rd_w=5, writeData=0x1234, regWrite=1, retired=1; a register file read of 5 after the following edge returns 0x1234.
- Source select: three back-to-back instructions:
  - Load, rd=8, load=0xDEADBEEF -> writeData=0xDEADBEEF.
  - Link, rd=31, pc4=0x0040_0008 -> writeData=0x0040_0008.
  - Reserved, wbSel=11 -> writeData=0.
  - Expected: one per cycle, retired=3.
- $0 and bypass: write rd=0 -> regWrite=0, byp hits 0. Write rd=9 with rs_1=9, rt_2=9 -> byp1_hit=byp2_hit=1. With rs_1=10 -> byp1_hit=0.
- Bubbles/flush: valid=0, then valid=1 with flush=1 and rd=4 -> regWrite stays 0, retired unchanged.
- Halt: halt instruction with regWrite=1, rd=2 -> regWrite=0, halted=1, retired+1. Subsequent valid writes are ignored for 10 cycles. Flush on a halt instead -> halted stays 0.
- Reset: assert rst_n=0 while regWrite=1 -> next cycle all outputs 0 and halted=0. Also set retired to all-ones (CNT_W=4) and retire one more -> wraps to 0.
